// File: rtl/spinet_ring_arbiter_if.sv
// Handshake bundle between the spinet node tx buffers and the ring injection arbiter.
// The master side is the set of requesting nodes; the slave side is the arbiter.
interface spinet_ring_arbiter_if #(
  parameter int N = 4
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic            tmo;
  logic [ID_W-1:0] tmo_id;

  modport master (
    output req, done,
    input  grant, grant_id, busy, tmo, tmo_id
  );

  modport slave (
    input  req, done,
    output grant, grant_id, busy, tmo, tmo_id
  );
endinterface

// File: rtl/spinet_ring_arbiter.sv
// Round-robin arbiter for the spinet ring's single injection slot, with watchdog and turnaround gap.
// Define SPINET_ARB_PRIO_EN to make node 0 a high-priority requester that bypasses the rotation.
module spinet_ring_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spinet_ring_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N);
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0]   TMR_MAX  = '1;
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP - 1);
  localparam logic [ID_W-1:0] PTR_RST  = ID_W'(N - 1);
  localparam logic [N-1:0]    ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            tmo_q, tmo_d;
  logic [ID_W-1:0] tmo_id_q, tmo_id_d;

  logic [ID_W-1:0] rr_winner;
  logic [ID_W-1:0] win_id;
  logic            win_upd_ptr;
  logic            rel_done, rel_drop, rel_tmo;

  // Search starts just after the last winner, so the last winner is checked last.
  always_comb begin : rr_search
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    rr_winner = '0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && bus.req[ID_W'(idx)]) begin
        found     = 1'b1;
        rr_winner = ID_W'(idx);
      end
    end
  end

`ifdef SPINET_ARB_PRIO_EN
  // A priority grant leaves ptr alone so nodes 1..N-1 keep their rotation.
  assign win_id      = bus.req[0] ? '0 : rr_winner;
  assign win_upd_ptr = !bus.req[0];
`else
  assign win_id      = rr_winner;
  assign win_upd_ptr = 1'b1;
`endif

  assign rel_done = bus.done[grant_id_q];
  assign rel_drop = !bus.req[grant_id_q];
  assign rel_tmo  = (TIMEOUT != 0) && (timer_q == TMO_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    tmo_d      = 1'b0;
    tmo_id_d   = tmo_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          grant_d    = ONE_HOT0 << win_id;
          grant_id_d = win_id;
          if (win_upd_ptr) ptr_d = win_id;
          timer_d    = '0;
          state_d    = S_GRANT;
        end
      end

      S_GRANT: begin
        if (rel_done || rel_drop || rel_tmo) begin
          grant_d = '0;
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
          // Watchdog is reported only when the node did not end the grant itself.
          if (!rel_done && !rel_drop) begin
            tmo_d    = 1'b1;
            tmo_id_d = grant_id_q;
          end
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= PTR_RST;
      timer_q    <= '0;
      gap_q      <= '0;
      tmo_q      <= 1'b0;
      tmo_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      tmo_id_q   <= tmo_id_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tmo      = tmo_q;
  assign bus.tmo_id   = tmo_id_q;

endmodule

// File: tb/tb_spinet_ring_arbiter.sv
// Scoreboard bench for spinet_ring_arbiter: stimulus queues expected grants/timeouts,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_spinet_ring_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 1;

  typedef struct {
    logic [N-1:0] grant;
    int           len;   // -1: length not checked
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spinet_ring_arbiter_if #(.N(N)) bus ();

  spinet_ring_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t exp_q[$];
  int   tmo_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [N-1:0] prev_grant;
    exp_t cur;
    bit   have_cur, in_gap;
    int   len, gap_cnt;
    prev_grant = '0; have_cur = 0; in_gap = 0; len = 0; gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_grant = '0; have_cur = 0; in_gap = 0;
      end else begin
        if (bus.tmo) begin
          if (tmo_q.size() == 0) fail("tmo_unexpected", $sformatf("tmo_id=%0d", bus.tmo_id));
          else check("tmo_id", 32'(bus.tmo_id), 32'(tmo_q.pop_front()));
        end
        if (bus.grant != '0 && prev_grant == '0) begin
          if (exp_q.size() == 0) begin
            fail("grant_unexpected", $sformatf("grant=%b", bus.grant));
          end else begin
            cur = exp_q.pop_front();
            check("grant", 32'(bus.grant), 32'(cur.grant));
            have_cur = 1; len = 0;
          end
        end
        if (bus.grant != '0) begin
          len++;
          if (prev_grant != '0) check("grant_stable", 32'(bus.grant), 32'(prev_grant));
        end
        if (bus.grant == '0 && prev_grant != '0) begin
          if (have_cur && cur.len >= 0) check("grant_len", 32'(len), 32'(cur.len));
          have_cur = 0; in_gap = 1; gap_cnt = 0;
        end
        if (in_gap) begin
          if (bus.busy && bus.grant == '0) gap_cnt++;
          else if (!bus.busy) begin
            check("gap_len", 32'(gap_cnt), 32'(GAP));
            in_gap = 0;
          end
        end
        prev_grant = bus.grant;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] g, input int len);
    exp_t e;
    e.grant = g;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (bus.grant == '0 && n < 200) begin tick(); n++; end
    if (bus.grant == '0) fail(name, "no grant within 200 cycles");
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    while (bus.grant != '0 && n < 200) begin tick(); n++; end
    if (bus.grant != '0) fail(name, "grant not released within 200 cycles");
  endtask

  // Serve whichever node holds the grant: done after 2 grant cycles, and drop its request.
  task automatic serve(input string name);
    logic [N-1:0] g;
    wait_grant(name);
    g = bus.grant;
    tick();
    bus.done = g;
    bus.req  = bus.req & ~g;
    tick();
    bus.done = '0;
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [N-1:0] g;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    repeat (3) tick();

    // 1: reset values, then idle with no requests
    check("rst_grant",    32'(bus.grant),    32'h0);
    check("rst_grant_id", 32'(bus.grant_id), 32'h0);
    check("rst_busy",     32'(bus.busy),     32'h0);
    check("rst_tmo",      32'(bus.tmo),      32'h0);
    check("rst_tmo_id",   32'(bus.tmo_id),   32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_quiet", 32'({bus.grant, bus.busy, bus.tmo}), 32'h0);
    end

    // 2: all requesting, done 3 cycles into each grant
`ifdef SPINET_ARB_PRIO_EN
    for (int i = 0; i < 5; i++) push(4'b0001, 3);
`else
    push(4'b0001, 3); push(4'b0010, 3); push(4'b0100, 3);
    push(4'b1000, 3); push(4'b0001, 3);
`endif
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rotate_wait");
      g = bus.grant;
      repeat (2) tick();
      bus.done = g;
      if (k == 4) bus.req = '0;
      tick();
      bus.done = '0;
    end
    repeat (3) tick();

    // 3: lone requester that never finishes hits the watchdog, then is re-granted
    push(4'b0100, TIMEOUT);
    push(4'b0100, 2);
    tmo_q.push_back(2);
    bus.req = 4'b0100;
    wait_grant("tmo_wait");
    wait_release("tmo_release");
    wait_grant("tmo_regrant");
    tick();
    bus.req = '0;
    repeat (3) tick();
    check("tmo_id_held", 32'(bus.tmo_id), 32'd2);

    // 4a: granted node drops its request mid-grant
    push(4'b0010, 2);
    bus.req = 4'b0010;
    wait_grant("drop_wait");
    tick();
    bus.req = '0;
    repeat (3) tick();

    // 4b: done in the very cycle the watchdog would fire
    push(4'b1000, TIMEOUT);
    bus.req = 4'b1000;
    wait_grant("done_tmo_wait");
    repeat (TIMEOUT - 1) tick();
    bus.done = 4'b1000;
    tick();
    bus.done = '0;
    bus.req  = '0;
    repeat (3) tick();
    check("done_wins_tmo_id", 32'(bus.tmo_id), 32'd2);

    // 5: reset during a grant, then arbitration restarts from ptr=N-1
    push(4'b1000, -1);
    bus.req = 4'b1000;
    wait_grant("rst_wait");
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(bus.grant), 32'h0);
    check("async_rst_busy",  32'(bus.busy),  32'h0);
    check("async_rst_tmo_id", 32'(bus.tmo_id), 32'h0);
    tick();
    bus.req = 4'b1001;
    tick();
    rst_n = 1'b1;
    push(4'b0001, 3);
    push(4'b1000, 2);
    wait_grant("post_rst_wait");
    repeat (2) tick();
    bus.done = 4'b0001;
    bus.req  = 4'b1000;
    tick();
    bus.done = '0;
    wait_grant("post_rst_second");
    tick();
    bus.req = '0;
    repeat (3) tick();

    // 6: ptr=1 with nodes 1,2 pending when node 0 rises
    push(4'b0010, 2);
    bus.req = 4'b0010;
    wait_grant("prio_setup");
    tick();
    bus.done = 4'b0010;
    bus.req  = 4'b0111;
    tick();
    bus.done = '0;
`ifdef SPINET_ARB_PRIO_EN
    push(4'b0001, 2); push(4'b0100, 2);
`else
    push(4'b0100, 2); push(4'b0001, 2);
`endif
    push(4'b0010, 2);
    serve("prio_first");
    serve("prio_second");
    serve("prio_third");
    repeat (5) tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("tmo_q_drained", 32'(tmo_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
